// File: rtl/proc_control.sv
// Instruction sequencer for the 9-bit bus processor: latches IR in T0 and walks
// T1..T3, decoding (state, IR) into bus-source selects, load enables and ALU op.
module proc_control (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [8:0] DIN,
    output logic [7:0] Rout,
    output logic       Gout,
    output logic       DINout,
    output logic [7:0] Rin,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       IRin,
    output logic       Done,
    output logic       Busy,
    output logic [1:0] fsm_state,
    output logic [8:0] ir_word
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     state;
    state_t     next_state;
    logic [8:0] ir;
    logic [2:0] opcode;
    logic [7:0] x_sel;
    logic [7:0] y_sel;

    assign opcode = ir[8:6];
    assign x_sel  = 8'b1 << ir[5:3];
    assign y_sel  = 8'b1 << ir[2:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= T0;
            ir    <= 9'h000;
        end else begin
            state <= next_state;
            if (IRin) begin
                ir <= DIN;
            end
        end
    end

    // Only one bus source is ever selected per step, so the mux never sees a conflict.
    always_comb begin
        next_state = state;
        Rout       = 8'h00;
        Gout       = 1'b0;
        DINout     = 1'b0;
        Rin        = 8'h00;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        IRin       = 1'b0;
        Done       = 1'b0;
        if (!Reset) begin
            case (state)
                T0: begin
                    IRin = Run;
                    if (Run) begin
                        next_state = T1;
                    end
                end
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            Rout       = y_sel;
                            Rin        = x_sel;
                            Done       = 1'b1;
                            next_state = T0;
                        end
                        OP_MVI: begin
                            DINout     = 1'b1;
                            Rin        = x_sel;
                            Done       = 1'b1;
                            next_state = T0;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout       = x_sel;
                            Ain        = 1'b1;
                            next_state = T2;
                        end
                        default: begin
                            Done       = 1'b1;
                            next_state = T0;
                        end
                    endcase
                end
                T2: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        Rout       = y_sel;
                        Gin        = 1'b1;
                        AddSub     = opcode[0];
                        next_state = T3;
                    end else begin
                        next_state = T0;
                    end
                end
                T3: begin
                    Gout       = 1'b1;
                    Rin        = x_sel;
                    Done       = 1'b1;
                    next_state = T0;
                end
                default: next_state = T0;
            endcase
        end
    end

    assign Busy      = (state != T0);
    assign fsm_state = state;
    assign ir_word   = ir;

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: fixed vector table, reset corner cases and randomized
// instruction streams checked against a per-instruction step model.
module tb_proc_control;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [8:0] DIN;
    logic [7:0] Rout;
    logic       Gout;
    logic       DINout;
    logic [7:0] Rin;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       IRin;
    logic       Done;
    logic       Busy;
    logic [1:0] fsm_state;
    logic [8:0] ir_word;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] rout;
        logic       gout;
        logic       dinout;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       irin;
        logic       done;
        logic       busy;
    } outs_t;

    typedef struct {
        string      name;
        logic [8:0] din;
        int         n_steps;
        outs_t      exp[3];
    } vec_t;

    proc_control dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
        .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .IRin(IRin),
        .Done(Done), .Busy(Busy), .fsm_state(fsm_state), .ir_word(ir_word)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic outs_t mk(logic [7:0] rout, logic gout, logic dinout, logic [7:0] rin,
                                 logic ain, logic gin, logic addsub, logic irin,
                                 logic done, logic busy);
        outs_t o;
        o.rout = rout; o.gout = gout; o.dinout = dinout; o.rin = rin;
        o.ain = ain; o.gin = gin; o.addsub = addsub; o.irin = irin;
        o.done = done; o.busy = busy;
        return o;
    endfunction

    function automatic outs_t actual();
        return mk(Rout, Gout, DINout, Rin, Ain, Gin, AddSub, IRin, Done, Busy);
    endfunction

    task automatic check_outs(string name, outs_t exp);
        outs_t act;
        act = actual();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rout=%h gout=%b dinout=%b rin=%h ain=%b gin=%b addsub=%b irin=%b done=%b busy=%b, want rout=%h gout=%b dinout=%b rin=%h ain=%b gin=%b addsub=%b irin=%b done=%b busy=%b",
                     name, act.rout, act.gout, act.dinout, act.rin, act.ain, act.gin, act.addsub,
                     act.irin, act.done, act.busy, exp.rout, exp.gout, exp.dinout, exp.rin,
                     exp.ain, exp.gin, exp.addsub, exp.irin, exp.done, exp.busy);
        end
    endtask

    task automatic check_ir(string name, logic [8:0] exp);
        n_checks++;
        if (ir_word !== exp) begin
            n_fail++;
            $display("FAIL %s: ir got %h want %h", name, ir_word, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, advance past the edge.
    task automatic step(logic run, logic [8:0] din, outs_t exp, string name);
        Run = run;
        DIN = din;
        @(negedge Clock);
        check_outs(name, exp);
        @(posedge Clock);
        #1;
    endtask

    // Reference: the per-timestep output list of one instruction after acceptance.
    function automatic void model(logic [8:0] instr, output int n, output outs_t seq[3]);
        int         op;
        logic [7:0] x;
        logic [7:0] y;
        op = int'(instr[8:6]);
        x  = 8'(2 ** int'(instr[5:3]));
        y  = 8'(2 ** int'(instr[2:0]));
        seq[0] = '0; seq[1] = '0; seq[2] = '0;
        if (op == 0) begin
            n = 1; seq[0] = mk(y, 0, 0, x, 0, 0, 0, 0, 1, 1);
        end else if (op == 1) begin
            n = 1; seq[0] = mk(0, 0, 1, x, 0, 0, 0, 0, 1, 1);
        end else if (op == 2 || op == 3) begin
            n = 3;
            seq[0] = mk(x, 0, 0, 0, 1, 0, 0, 0, 0, 1);
            seq[1] = mk(y, 0, 0, 0, 0, 1, (op == 3), 0, 0, 1);
            seq[2] = mk(0, 1, 0, x, 0, 0, 0, 0, 1, 1);
        end else begin
            n = 1; seq[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        end
    endfunction

    // Select exclusivity and one-hot selects, every cycle.
    always @(negedge Clock) begin
        n_checks++;
        if ((int'(Gout) + int'(DINout) + int'(Rout != 8'h00)) > 1 || !$onehot0(Rout) || !$onehot0(Rin)) begin
            n_fail++;
            $display("FAIL select_invariant: gout=%b dinout=%b rout=%h rin=%h", Gout, DINout, Rout, Rin);
        end
    end

    initial begin
        vec_t  vecs[8];
        outs_t zero;
        outs_t issue;
        outs_t seq[3];
        int    n;
        logic [8:0] instr;

        zero  = '0;
        issue = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        vecs[0] = '{"mvi_r0", 9'h040, 1, '{mk(8'h00,0,1,8'h01,0,0,0,0,1,1), zero, zero}};
        vecs[1] = '{"mv_r1_r0", 9'h008, 1, '{mk(8'h01,0,0,8'h02,0,0,0,0,1,1), zero, zero}};
        vecs[2] = '{"add_r0_r1", 9'h081, 3, '{mk(8'h01,0,0,8'h00,1,0,0,0,0,1),
                                              mk(8'h02,0,0,8'h00,0,1,0,0,0,1),
                                              mk(8'h00,1,0,8'h01,0,0,0,0,1,1)}};
        vecs[3] = '{"sub_r2_r3", 9'h0D3, 3, '{mk(8'h04,0,0,8'h00,1,0,0,0,0,1),
                                              mk(8'h08,0,0,8'h00,0,1,1,0,0,1),
                                              mk(8'h00,1,0,8'h04,0,0,0,0,1,1)}};
        vecs[4] = '{"reserved", 9'h1FF, 1, '{mk(8'h00,0,0,8'h00,0,0,0,0,1,1), zero, zero}};
        vecs[5] = '{"mv_r3_r3", 9'h01B, 1, '{mk(8'h08,0,0,8'h08,0,0,0,0,1,1), zero, zero}};
        vecs[6] = '{"mvi_r7", 9'h078, 1, '{mk(8'h00,0,1,8'h80,0,0,0,0,1,1), zero, zero}};
        vecs[7] = '{"add_r7_r6", 9'h0BE, 3, '{mk(8'h80,0,0,8'h00,1,0,0,0,0,1),
                                              mk(8'h40,0,0,8'h00,0,1,0,0,0,1),
                                              mk(8'h00,1,0,8'h80,0,0,0,0,1,1)}};

        // Reset held with Run high: IRin must stay low.
        Reset = 1'b1;
        Run   = 1'b1;
        DIN   = 9'h1FF;
        @(negedge Clock);
        check_outs("reset_hold", zero);
        check_ir("reset_ir", 9'h000);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 9'($urandom), zero, "idle_after_reset");
        end
        check_ir("idle_ir", 9'h000);

        // Fixed vectors, issued back-to-back; Run held high and DIN scrambled while busy.
        for (int v = 0; v < 8; v++) begin
            step(1'b1, vecs[v].din, issue, {vecs[v].name, "_t0"});
            check_ir({vecs[v].name, "_ir"}, vecs[v].din);
            for (int s = 0; s < vecs[v].n_steps; s++) begin
                step(1'b1, (v == 0) ? 9'd5 : 9'($urandom), vecs[v].exp[s], $sformatf("%s_t%0d", vecs[v].name, s + 1));
            end
        end
        step(1'b0, 9'h000, zero, "idle_after_table");

        // Reset during T2 of an add: outputs drop immediately, nothing retires afterwards.
        step(1'b1, 9'h081, issue, "rst_add_t0");
        step(1'b0, 9'h000, vecs[2].exp[0], "rst_add_t1");
        Reset = 1'b1;
        Run   = 1'b1;
        #1;
        check_outs("rst_mid_instr", zero);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check_ir("rst_mid_ir", 9'h000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 9'($urandom), zero, "after_mid_reset");
        end

        // Randomized instruction stream against the model.
        for (int k = 0; k < 150; k++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) begin
                step(1'b0, 9'($urandom), zero, "rand_idle");
            end
            instr = 9'($urandom);
            model(instr, n, seq);
            step(1'b1, instr, issue, "rand_issue");
            for (int s = 0; s < n; s++) begin
                step(1'($urandom_range(0, 1)), 9'($urandom), seq[s], $sformatf("rand_%h_t%0d", instr, s + 1));
            end
        end
        step(1'b0, 9'h000, zero, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
